// File: rtl/delay_tap_sequencer_if.sv
// delay_tap_sequencer_if
//  Groups the block-control, sample-handshake and delay-line control signals of
//  the delay tap sequencer into one bundle.
//  Signals:
//   iStart, iOrder, iBlockSize  block start request with predictor order / size
//   iValid / oReady             upstream sample handshake
//   oDelayEnable, oDelayM       delay line enable and tap select
//   oValid, oWarmup, oLast      delayed-sample qualifiers
//   oBusy, oDone, oError        block status
//  Modports:
//   master  the upstream / control side that drives the block requests
//   slave   the sequencer itself
interface delay_tap_sequencer_if #(
  parameter int CNT_W = 16
);
  logic             iStart;
  logic [3:0]       iOrder;
  logic [CNT_W-1:0] iBlockSize;
  logic             iValid;
  logic             oReady;
  logic             oDelayEnable;
  logic [3:0]       oDelayM;
  logic             oValid;
  logic             oWarmup;
  logic             oLast;
  logic             oBusy;
  logic             oDone;
  logic             oError;

  modport master (
    output iStart, iOrder, iBlockSize, iValid,
    input  oReady, oDelayEnable, oDelayM, oValid, oWarmup, oLast, oBusy, oDone, oError
  );

  modport slave (
    input  iStart, iOrder, iBlockSize, iValid,
    output oReady, oDelayEnable, oDelayM, oValid, oWarmup, oLast, oBusy, oDone, oError
  );
endinterface

// File: rtl/delay_tap_sequencer.sv
// delay_tap_sequencer
//  Block-level controller for the 16-bit tapped delay line in the encoder
//  residual path. At block start it latches the predictor order and block
//  size, then gates samples from the sample FIFO into the delay line, drives
//  the delay line enable and tap select, and tags each delayed sample as
//  warm-up or residual, marking the final sample of the block.
//  Ports:
//   iClock    rising-edge clock
//   iReset_n  synchronous reset, active low
//   bus       delay_tap_sequencer_if.slave (handshake, delay-line control, status)
module delay_tap_sequencer #(
  parameter int CNT_W     = 16,
  parameter int MAX_ORDER = 12
) (
  input  logic                  iClock,
  input  logic                  iReset_n,
  delay_tap_sequencer_if.slave  bus
);

  localparam logic [3:0] ORDER_BYPASS = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FLUSH,
    ST_ERR
  } state_t;

  state_t           state_reg, state_next;
  logic [3:0]       order_reg, order_next;
  logic [CNT_W-1:0] size_reg, size_next;
  logic [CNT_W-1:0] count_reg, count_next;
  logic             valid_reg, valid_next;
  logic             warmup_reg, warmup_next;
  logic             last_reg, last_next;
  logic             done_reg, done_next;

  // Lookup of which 4-bit order codes are accepted: 0..MAX_ORDER plus bypass.
  logic [15:0] order_legal_vec;
  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_order_legal
      assign order_legal_vec[gi] = (gi <= MAX_ORDER) || (gi == 15);
    end
  endgenerate

  logic order_legal;
  logic accept;
  logic is_last_sample;

  assign order_legal    = order_legal_vec[bus.iOrder];
  assign accept         = bus.iValid && (state_reg == ST_RUN);
  assign is_last_sample = (count_reg == size_reg - CNT_W'(1));

  always_ff @(posedge iClock) begin
    if (!iReset_n) begin
      state_reg  <= ST_IDLE;
      order_reg  <= '0;
      size_reg   <= '0;
      count_reg  <= '0;
      valid_reg  <= 1'b0;
      warmup_reg <= 1'b0;
      last_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      order_reg  <= order_next;
      size_reg   <= size_next;
      count_reg  <= count_next;
      valid_reg  <= valid_next;
      warmup_reg <= warmup_next;
      last_reg   <= last_next;
      done_reg   <= done_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    order_next  = order_reg;
    size_next   = size_reg;
    count_next  = count_reg;
    valid_next  = 1'b0;
    warmup_next = 1'b0;
    last_next   = 1'b0;
    done_next   = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        if (bus.iStart) begin
          if (order_legal) begin
            order_next = bus.iOrder;
            size_next  = bus.iBlockSize;
            count_next = '0;
            state_next = ST_RUN;
          end else begin
            // Illegal order: nothing is latched so oDelayM keeps the old tap.
            state_next = ST_ERR;
          end
        end
      end
      ST_RUN: begin
        if (accept) begin
          count_next  = count_reg + CNT_W'(1);
          valid_next  = 1'b1;
          // Bypass never warms up; order 0 falls out of the compare naturally.
          warmup_next = (order_reg != ORDER_BYPASS) && (count_reg < CNT_W'(order_reg));
          last_next   = is_last_sample;
          if (is_last_sample) begin
            state_next = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        // The last sample is on the outputs now; oDone lands in the next IDLE
        // cycle, where a new iStart may already be accepted.
        done_next  = 1'b1;
        state_next = ST_IDLE;
      end
      ST_ERR: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.oReady       = (state_reg == ST_RUN);
  assign bus.oDelayEnable = accept;
  assign bus.oDelayM      = order_reg;
  assign bus.oValid       = valid_reg;
  assign bus.oWarmup      = warmup_reg;
  assign bus.oLast        = last_reg;
  assign bus.oBusy        = (state_reg != ST_IDLE);
  assign bus.oDone        = done_reg;
  assign bus.oError       = (state_reg == ST_ERR);

endmodule
